// File: rtl/pulse_pkg.sv
// Shared types for the debounced edge detector: FSM state encoding and
// edge-selection constants.
package pulse_pkg;

  typedef enum logic [1:0] {
    LOW_STABLE  = 2'd0,
    CHECK_HIGH  = 2'd1,
    HIGH_STABLE = 2'd2,
    CHECK_LOW   = 2'd3
  } state_e;

  localparam int unsigned EDGE_RISE = 0;
  localparam int unsigned EDGE_FALL = 1;
  localparam int unsigned EDGE_BOTH = 2;

  // Unknown edge modes fall back to rising-edge pulses.
  function automatic int unsigned norm_edge_mode(input int unsigned mode);
    if (mode == EDGE_FALL || mode == EDGE_BOTH) begin
      return mode;
    end
    return EDGE_RISE;
  endfunction

endpackage

// File: rtl/sync_chain.sv
// Multi-flop synchroniser for one asynchronous bit; q is the last stage.
module sync_chain #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      chain_q <= '0;
    end else begin
      chain_q <= {chain_q[STAGES-2:0], d};
    end
  end

  assign q = chain_q[STAGES-1];

endmodule

// File: rtl/pulse_debounce_edge.sv
// Debounces a raw level, reports the clean level, and pulses/counts on the
// selected edge(s) of that clean level.
module pulse_debounce_edge
  import pulse_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned EDGE_MODE       = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sig_in,
  output logic       level_out,
  output logic       pulse_out,
  output logic [7:0] edge_count,
  output state_e     state_dbg
);

  localparam int unsigned MODE       = norm_edge_mode(EDGE_MODE);
  localparam bit          PULSE_RISE = (MODE == EDGE_RISE) || (MODE == EDGE_BOTH);
  localparam bit          PULSE_FALL = (MODE == EDGE_FALL) || (MODE == EDGE_BOTH);
  localparam logic [7:0]  DEB        = 8'(DEBOUNCE_CYCLES);

  logic       s;
  state_e     state_q;
  logic [7:0] cnt_q;
  logic       level_q;
  logic       pulse_q;
  logic [7:0] count_q;
  logic       rise_done;
  logic       fall_done;

  sync_chain #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (sig_in),
    .q  (s)
  );

  // The counter holds samples already seen, so the current sample completes
  // the run when cnt_q reaches DEB-1; with DEB=1 the stable state qualifies
  // directly on the first opposite sample.
  always_comb begin
    rise_done = 1'b0;
    fall_done = 1'b0;
    if (s) begin
      rise_done = ((state_q == LOW_STABLE) && (DEB == 8'd1)) ||
                  ((state_q == CHECK_HIGH) && (cnt_q >= DEB - 8'd1));
    end else begin
      fall_done = ((state_q == HIGH_STABLE) && (DEB == 8'd1)) ||
                  ((state_q == CHECK_LOW) && (cnt_q >= DEB - 8'd1));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LOW_STABLE;
      cnt_q   <= '0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
      count_q <= '0;
    end else begin
      if ((rise_done && PULSE_RISE) || (fall_done && PULSE_FALL)) begin
        pulse_q <= 1'b1;
        count_q <= count_q + 8'd1;
      end else begin
        pulse_q <= 1'b0;
      end

      if (rise_done) begin
        state_q <= HIGH_STABLE;
        level_q <= 1'b1;
        cnt_q   <= '0;
      end else if (fall_done) begin
        state_q <= LOW_STABLE;
        level_q <= 1'b0;
        cnt_q   <= '0;
      end else begin
        case (state_q)
          LOW_STABLE: begin
            if (s) begin
              state_q <= CHECK_HIGH;
              cnt_q   <= 8'd1;
            end
          end
          CHECK_HIGH: begin
            if (!s) begin
              state_q <= LOW_STABLE;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + 8'd1;
            end
          end
          HIGH_STABLE: begin
            if (!s) begin
              state_q <= CHECK_LOW;
              cnt_q   <= 8'd1;
            end
          end
          CHECK_LOW: begin
            if (s) begin
              state_q <= HIGH_STABLE;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + 8'd1;
            end
          end
          default: begin
            state_q <= LOW_STABLE;
            cnt_q   <= '0;
          end
        endcase
      end
    end
  end

  assign level_out  = level_q;
  assign pulse_out  = pulse_q;
  assign edge_count = count_q;
  assign state_dbg  = state_q;

endmodule
